// File: rtl/ccs_adc2axi4lite.sv
// ccs_adc2axi4lite: single-outstanding command/response to AXI4-Lite master bridge
// All VALID/READY outputs are registered; ERR_INIT only exists to seed the error counter.
module ccs_adc2axi4lite #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 64,
    parameter logic [15:0] ERR_INIT   = 16'h0000
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [15:0]             err_count,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [2:0]              awprot,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [2:0]              arprot,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
    state_t state;
    logic aw_next, w_next, cap_err;
    assign awprot  = 3'b000;
    assign arprot  = 3'b000;
    assign aw_next = awvalid & ~awready;
    assign w_next  = wvalid & ~wready;
    // SLVERR/DECERR both carry resp[1]=1
    assign cap_err = (state == WR_RESP && bvalid && bresp[1]) || (state == RD_RESP && rvalid && rresp[1]);
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            err_count <= ERR_INIT;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            if (cap_err && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                // AW and W channels retire independently, in any order
                WR_REQ: begin
                    awvalid <= aw_next;
                    wvalid  <= w_next;
                    if (!aw_next && !w_next) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_resp  <= bresp;
                        state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata;
                        rsp_resp  <= rresp;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ccs_adc2axi4lite.sv
// tb_ccs_adc2axi4lite: directed bench with a command-level response model and a bus-level slave
`timescale 1ns/1ps
module tb_ccs_adc2axi4lite;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic arst_n = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          cmd_ready, rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [15:0]   err_count;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [2:0]    awprot, arprot;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;
    logic [DW-1:0] rdata = '0;

    // second instance shares every input; only its pre-seeded error counter is inspected
    logic          x_cmd_ready, x_rsp_valid, x_awvalid, x_wvalid, x_bready, x_arvalid, x_rready;
    logic [DW-1:0] x_rsp_rdata, x_wdata;
    logic [1:0]    x_rsp_resp;
    logic [15:0]   x_err_count;
    logic [AW-1:0] x_awaddr, x_araddr;
    logic [2:0]    x_awprot, x_arprot;
    logic [SW-1:0] x_wstrb;

    ccs_adc2axi4lite #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .arst_n(arst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .err_count(err_count),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awprot(awprot),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arprot(arprot),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    ccs_adc2axi4lite #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_INIT(16'hFFFD)) dut_sat (
        .clk(clk), .arst_n(arst_n),
        .cmd_valid(cmd_valid), .cmd_ready(x_cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(x_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(x_rsp_rdata), .rsp_resp(x_rsp_resp),
        .err_count(x_err_count),
        .awaddr(x_awaddr), .awvalid(x_awvalid), .awready(awready), .awprot(x_awprot),
        .wdata(x_wdata), .wstrb(x_wstrb), .wvalid(x_wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(x_bready),
        .araddr(x_araddr), .arvalid(x_arvalid), .arready(arready), .arprot(x_arprot),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(x_rready)
    );

    int errors = 0, checks = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic [DW-1:0] v;
        v = old;
        for (int i = 0; i < SW; i++)
            if (s[i]) v[8*i +: 8] = d[8*i +: 8];
        return v;
    endfunction

    // command-level model: memory image and queue of expected {resp, rdata}
    logic [DW-1:0] mmem [int];
    logic [65:0]   exp_q [$];
    logic [65:0]   e_cur;
    logic [15:0]   err_exp = 16'h0000, err2_exp = 16'hFFFD;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic [SW-1:0] cur_wstrb = '0;

    // slave configuration and state
    int            aw_dly = 0, w_dly = 0, ar_dly = 0;
    int            aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic [1:0]    resp_cfg = 2'b00;
    bit            b_hold = 0, got_aw = 0, got_w = 0;
    logic [DW-1:0] smem [int];
    logic [AW-1:0] sl_awaddr, sl_araddr;
    logic [DW-1:0] sl_wdata;
    logic [SW-1:0] sl_wstrb;

    // compare process
    int            cyc = 0, n_rsp = 0, rsp_cyc = -10, cmd_cyc = -10, aw_hi = 0, w_hi = 0;
    bit            aw_hs, w_hs, b_hs, ar_hs, r_hs, pv = 0;
    logic [DW-1:0] prd, last_rdata = '0;
    logic [1:0]    prr;
    always @(negedge clk) begin
        cyc++;
        aw_hs = awvalid & awready;
        w_hs  = wvalid & wready;
        b_hs  = bvalid & bready;
        ar_hs = arvalid & arready;
        r_hs  = rvalid & rready;
        if (arst_n) begin
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            if (cmd_ready || rsp_valid) chk("cmd_ready_with_rsp_valid", cmd_ready & rsp_valid, 0);
            if (bready) chk("bready_before_aw_w_done", awvalid | wvalid, 0);
            if (awvalid || arvalid) chk("prot", {awprot, arprot}, 0);
            if (pv) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_rdata", rsp_rdata, prd);
                chk("rsp_hold_resp", rsp_resp, prr);
            end
            if (aw_hs) begin chk("awaddr", awaddr, cur_addr); sl_awaddr = awaddr; end
            if (w_hs) begin
                chk("wdata", wdata, cur_wdata);
                chk("wstrb", wstrb, cur_wstrb);
                sl_wdata = wdata;
                sl_wstrb = wstrb;
            end
            if (ar_hs) begin chk("araddr", araddr, cur_addr); sl_araddr = araddr; end
            if (cmd_valid && cmd_ready) cmd_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                rsp_cyc = cyc;
                last_rdata = rsp_rdata;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e_cur[63:0]);
                    chk("rsp_resp", rsp_resp, e_cur[65:64]);
                    if (e_cur[65]) begin
                        err_exp  = (err_exp == 16'hFFFF) ? err_exp : err_exp + 16'd1;
                        err2_exp = (err2_exp == 16'hFFFF) ? err2_exp : err2_exp + 16'd1;
                    end
                    chk("err_count", err_count, err_exp);
                    chk("err_count_sat", x_err_count, err2_exp);
                end
            end
            pv  = rsp_valid & ~rsp_ready;
            prd = rsp_rdata;
            prr = rsp_resp;
        end else begin
            pv = 0;
        end
    end

    // AXI4-Lite slave; decides its outputs 1ns after each rising edge
    always @(posedge clk) begin
        #1;
        if (!arst_n) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        end else begin
            if (aw_hs) got_aw = 1;
            if (w_hs) got_w = 1;
            if (b_hs) bvalid = 0;
            if (r_hs) rvalid = 0;
            if (got_aw && got_w && !b_hold) begin
                smem[int'(sl_awaddr >> 3)] = merge(smem.exists(int'(sl_awaddr >> 3)) ? smem[int'(sl_awaddr >> 3)] : '0, sl_wdata, sl_wstrb);
                bvalid = 1; bresp = resp_cfg; got_aw = 0; got_w = 0;
            end
            if (ar_hs) begin
                rvalid = 1;
                rresp  = resp_cfg;
                rdata  = smem.exists(int'(sl_araddr >> 3)) ? smem[int'(sl_araddr >> 3)] : '0;
            end
            if (awvalid) begin awready = aw_cnt >= aw_dly; aw_cnt++; end else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = w_cnt >= w_dly; w_cnt++; end else begin wready = 0; w_cnt = 0; end
            if (arvalid) begin arready = ar_cnt >= ar_dly; ar_cnt++; end else begin arready = 0; ar_cnt = 0; end
        end
    end

    // all tasks start and end 1ns after a rising edge
    task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s, output int waits);
        bit hs;
        logic [DW-1:0] old;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        cur_addr = a; cur_wdata = d; cur_wstrb = s;
        waits = 0;
        forever begin
            @(negedge clk);
            waits++;
            hs = cmd_ready;
            @(posedge clk); #1;
            if (hs || waits > 40) break;
        end
        chk("cmd_accept", hs, 1);
        cmd_valid = 0;
        old = mmem.exists(int'(a >> 3)) ? mmem[int'(a >> 3)] : '0;
        if (wr) begin
            mmem[int'(a >> 3)] = merge(old, d, s);
            exp_q.push_back({resp_cfg, 64'h0});
        end else begin
            exp_q.push_back({resp_cfg, old});
        end
    endtask

    task automatic wait_rsp(input bit hs, output int lat);
        int n0;
        n0 = n_rsp;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (rsp_valid || lat > 40) break;
            @(posedge clk); #1;
        end
        chk("rsp_arrives", rsp_valid, 1);
        @(posedge clk); #1;
        if (hs) begin
            for (int i = 0; i < 40 && n_rsp == n0; i++) begin @(posedge clk); #1; end
            chk("rsp_count", n_rsp - n0, 1);
        end
    endtask

    task automatic do_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input bit hs, output int lat, output int waits);
        send_cmd(wr, a, d, s, waits);
        wait_rsp(hs, lat);
    endtask

    task automatic check_reset(input string t);
        chk({t, "_valid_ready"}, {cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready}, 0);
        chk({t, "_rsp_rdata"}, rsp_rdata, 0);
        chk({t, "_rsp_resp"}, rsp_resp, 0);
        chk({t, "_err_count"}, err_count, 0);
        chk({t, "_awaddr"}, awaddr, 0);
        chk({t, "_wdata"}, wdata, 0);
        chk({t, "_wstrb"}, wstrb, 0);
        chk({t, "_araddr"}, araddr, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int lat, w, n0;
    initial begin
        #1 arst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1 arst_n = 1;
        @(negedge clk);
        chk("cmd_ready_in_reset_release_cycle", cmd_ready, 0);
        @(posedge clk); #1;
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // zero-wait write then back-to-back reads
        aw_hi = 0; w_hi = 0;
        do_cmd(1, 12'h008, 64'h0000_0000_0000_0ABC, 8'hFF, 1, lat, w);
        chk("wr_latency", lat, 3);
        chk("wr_aw_cycles", aw_hi, 1);
        chk("wr_w_cycles", w_hi, 1);
        chk("slave_mem_008", smem.exists(1) ? smem[1] : '0, 64'hABC);
        do_cmd(0, 12'h008, '0, '0, 1, lat, w);
        chk("rd_latency", lat, 3);
        chk("rd_b2b_wait", w, 1);
        chk("rd_data_008", last_rdata, 64'hABC);

        // partial strobes
        do_cmd(1, 12'h010, 64'h1122_3344_5566_7788, 8'hFF, 1, lat, w);
        do_cmd(1, 12'h010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1, lat, w);
        do_cmd(0, 12'h010, '0, '0, 1, lat, w);
        chk("rd_strobed_010", last_rdata, 64'h1122_3344_AAAA_AAAA);

        // AWREADY late, then WREADY late
        aw_dly = 3; aw_hi = 0; w_hi = 0; n0 = n_rsp;
        do_cmd(1, 12'h020, 64'hDEAD_BEEF, 8'hFF, 1, lat, w);
        chk("aw_late_aw_cycles", aw_hi, 4);
        chk("aw_late_w_cycles", w_hi, 1);
        chk("aw_late_single_rsp", n_rsp - n0, 1);
        chk("aw_late_queue_empty", exp_q.size(), 0);
        aw_dly = 0; w_dly = 3; aw_hi = 0; w_hi = 0; n0 = n_rsp;
        do_cmd(1, 12'h028, 64'h0123_4567_89AB_CDEF, 8'hF0, 1, lat, w);
        chk("w_late_aw_cycles", aw_hi, 1);
        chk("w_late_w_cycles", w_hi, 4);
        chk("w_late_single_rsp", n_rsp - n0, 1);
        w_dly = 0; ar_dly = 2;
        do_cmd(0, 12'h028, '0, '0, 1, lat, w);
        chk("ar_late_latency", lat, 5);
        chk("rd_028", last_rdata, 64'h0123_4567_0000_0000);
        ar_dly = 0;

        // three SLVERR reads
        resp_cfg = 2'b10;
        repeat (3) do_cmd(0, 12'h008, '0, '0, 1, lat, w);
        resp_cfg = 2'b00;
        chk("err_count_three", err_count, 16'd3);
        chk("err_count_saturated", x_err_count, 16'hFFFF);

        // response back-pressure with a command waiting
        rsp_ready = 0;
        do_cmd(0, 12'h008, '0, '0, 0, lat, w);
        chk("held_rd_latency", lat, 3);
        fork
            send_cmd(1, 12'h030, 64'h55, 8'hFF, w);
            begin repeat (4) @(posedge clk); #1 rsp_ready = 1; end
        join
        chk("held_cmd_wait", w, 6);
        chk("held_cmd_after_rsp", cmd_cyc, rsp_cyc + 1);
        wait_rsp(1, lat);
        chk("held_next_wr_latency", lat, 3);

        // asynchronous reset while waiting for B
        b_hold = 1;
        send_cmd(1, 12'h018, 64'h77, 8'hFF, w);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bready) break;
        end
        chk("in_wr_resp", bready, 1);
        #2 arst_n = 0;
        #1 check_reset("mid_reset");
        exp_q.delete();
        err_exp = 16'h0000; err2_exp = 16'hFFFD; b_hold = 0;
        repeat (2) begin @(posedge clk); #1; end
        arst_n = 1;
        @(posedge clk); #1;
        chk("cmd_ready_after_mid_reset", cmd_ready, 1);
        do_cmd(0, 12'h010, '0, '0, 1, lat, w);
        chk("post_reset_rd_latency", lat, 3);
        chk("post_reset_rd_010", last_rdata, 64'h1122_3344_AAAA_AAAA);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
